// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N:1 channel multiplexer.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_e;

  // Select width for n channels, never below one bit (n = 2 still needs a bit,
  // and $clog2 of 1 would give a zero-width field).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Purely combinational N:1 select with range check.
// Out-of-range indices yield zero data and a raised error flag.
module mux_nto1_comb
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH*W-1:0] in_data_i,
  input  logic [SEL_W-1:0]  idx_i,
  output logic [W-1:0]      data_o,
  output logic              err_o
);

  // Scan every channel slot; indices matching none of them fall through as errors.
  always_comb begin
    data_o = '0;
    err_o  = 1'b1;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(idx_i) == k) begin
        data_o = in_data_i[k*W +: W];
        err_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_seq.sv
// Registered N:1 channel multiplexer with manual (per-request) and scan
// (full sweep) modes, presenting a valid/ready beat to a single consumer.
module mux_nto1_seq
  import mux_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SEL_W-1:0]  sel,
  input  logic              req,
  input  logic              start,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_e           state_q;
  logic [SEL_W-1:0] cnt_q;
  logic [W-1:0]     out_data_q;
  logic [SEL_W-1:0] out_ch_q;
  logic             out_err_q;
  logic             out_valid_q;

  logic             slot_free;
  logic             issue;
  logic [SEL_W-1:0] mux_idx;
  logic [W-1:0]     mux_data;
  logic             mux_err;

  assign slot_free = !out_valid_q || out_ready;
  assign mux_idx   = (state_q == SCAN) ? cnt_q : sel;

  // A beat is issued in SCAN whenever the slot frees up, or in IDLE on a
  // request that is not pre-empted by start.
  assign issue = slot_free &&
                 ((state_q == SCAN) || ((state_q == IDLE) && !start && req));

  mux_nto1_comb #(
    .N_CH  (N_CH),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_sel (
    .in_data_i (in_data),
    .idx_i     (mux_idx),
    .data_o    (mux_data),
    .err_o     (mux_err)
  );

  // Sequencer state, scan counter and output beat register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            cnt_q   <= '0;
          end
        end
        SCAN: begin
          if (slot_free) begin
            if (cnt_q == LAST_CH) begin
              cnt_q   <= '0;
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (issue) begin
        out_data_q  <= mux_data;
        out_ch_q    <= mux_idx;
        out_err_q   <= mux_err;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // done marks the cycle the final scan beat is taken, so the next start is
  // honoured one cycle later once the state is back in IDLE.
  assign done      = (state_q == DRAIN) && out_valid_q && out_ready;
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_seq.sv
// Self-checking bench: directed vectors plus a cycle-level behavioural model
// of the 8-channel instance, and literal checks on a 6-channel instance.
module tb_mux_nto1_seq;

  localparam int unsigned NA = 8;
  localparam int unsigned WA = 4;
  localparam int unsigned SA = 3;
  localparam int unsigned NB = 6;
  localparam int unsigned WB = 4;
  localparam int unsigned SB = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NA*WA-1:0] a_in;
  logic [SA-1:0]    a_sel;
  logic             a_req, a_start, a_ready;
  logic [WA-1:0]    a_data;
  logic [SA-1:0]    a_ch;
  logic             a_err, a_valid, a_busy, a_done;

  logic [NB*WB-1:0] b_in;
  logic [SB-1:0]    b_sel;
  logic             b_req, b_start, b_ready;
  logic [WB-1:0]    b_data;
  logic [SB-1:0]    b_ch;
  logic             b_err, b_valid, b_busy, b_done;

  mux_nto1_seq #(.N_CH(NA), .W(WA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in), .sel(a_sel), .req(a_req),
    .start(a_start), .out_data(a_data), .out_ch(a_ch), .out_err(a_err),
    .out_valid(a_valid), .out_ready(a_ready), .busy(a_busy), .done(a_done)
  );

  mux_nto1_seq #(.N_CH(NB), .W(WB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in), .sel(b_sel), .req(b_req),
    .start(b_start), .out_data(b_data), .out_ch(b_ch), .out_err(b_err),
    .out_valid(b_valid), .out_ready(b_ready), .busy(b_busy), .done(b_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut_a ----------------
  // mode: 0 idle, 1 sweeping, 2 waiting for last beat to be taken
  int          m_mode;
  int          m_next;
  logic        m_valid;
  logic [3:0]  m_data;
  int          m_ch;
  logic        m_err;
  int          acc_q[$];

  function automatic logic [3:0] chan_a(input int k);
    if (k >= 0 && k < int'(NA)) return 4'(a_in >> (k * int'(WA)));
    return 4'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_next = 0; m_valid = 1'b0; m_data = 4'h0; m_ch = 0; m_err = 1'b0;
    end else begin
      bit accept, free, iss;
      int ch;
      accept = m_valid && a_ready;
      free   = !m_valid || a_ready;
      iss    = 1'b0;
      ch     = 0;
      if (accept) acc_q.push_back(m_ch);
      if (m_mode == 0) begin
        if (a_start) begin m_mode = 1; m_next = 0; end
        else if (a_req && free) begin iss = 1'b1; ch = int'(a_sel); end
      end else if (m_mode == 1) begin
        if (free) begin
          iss = 1'b1; ch = m_next;
          if (m_next == int'(NA) - 1) begin m_next = 0; m_mode = 2; end
          else m_next++;
        end
      end else begin
        if (accept) m_mode = 0;
      end
      if (iss) begin
        m_valid = 1'b1; m_ch = ch; m_data = chan_a(ch); m_err = (ch >= int'(NA));
      end else if (accept) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmp_valid", a_valid, m_valid);
      chk("cmp_busy", a_busy, m_mode != 0);
      chk("cmp_done", a_done, (m_mode == 2) && a_ready);
      if (m_valid) begin
        chk("cmp_data", a_data, m_data);
        chk("cmp_ch", a_ch, m_ch);
        chk("cmp_err", a_err, m_err);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check_acc(input int base);
    chk("acc_count", acc_q.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < acc_q.size()) chk("acc_order", acc_q[base + i], i);
    end
  endtask

  // Called at negedge+1; start pulse with a competing req, req held during scan.
  task automatic scan_full();
    int base;
    base = acc_q.size();
    a_start = 1'b1; a_req = 1'b1; a_sel = 3'd2;
    @(negedge clk);
    chk("scan_nobeat", a_valid, 1'b0);
    chk("scan_busy0", a_busy, 1'b1);
    #1 a_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("scan_valid", a_valid, 1'b1);
      chk("scan_ch", a_ch, k);
      chk("scan_data", a_data, k);
      chk("scan_busy", a_busy, 1'b1);
      chk("scan_done", a_done, k == 7);
    end
    #1 a_req = 1'b0;
    @(negedge clk);
    chk("post_busy", a_busy, 1'b0);
    chk("post_valid", a_valid, 1'b0);
    chk("post_done", a_done, 1'b0);
    check_acc(base);
    #1;
  endtask

  initial begin
    int base;
    bit seen;
    rst_n = 1'b0;
    a_in = 32'h7654_3210; a_sel = '0; a_req = 1'b0; a_start = 1'b0; a_ready = 1'b1;
    b_in = 24'h54_3210;   b_sel = '0; b_req = 1'b0; b_start = 1'b0; b_ready = 1'b1;
    #2;
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_data", a_data, 4'h0);
    chk("rst_b_valid", b_valid, 1'b0);
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;

    // manual beats
    a_req = 1'b1; a_sel = 3'd5; b_req = 1'b1; b_sel = 3'd7;
    @(negedge clk);
    chk("man_valid", a_valid, 1'b1);
    chk("man_data", a_data, 4'h5);
    chk("man_ch", a_ch, 3'd5);
    chk("man_err", a_err, 1'b0);
    chk("oor_valid", b_valid, 1'b1);
    chk("oor_data", b_data, 4'h0);
    chk("oor_ch", b_ch, 3'd7);
    chk("oor_err", b_err, 1'b1);
    #1 a_req = 1'b0; b_sel = 3'd3;
    @(negedge clk);
    chk("man_drop_valid", a_valid, 1'b0);
    chk("b_in_valid", b_valid, 1'b1);
    chk("b_in_data", b_data, 4'h3);
    chk("b_in_err", b_err, 1'b0);
    #1 b_req = 1'b0;
    @(negedge clk);
    #1;

    // full sweep, start wins over req, req ignored during scan
    scan_full();

    // sweep with a stall on the ch2 beat while in_data changes
    base = acc_q.size();
    a_start = 1'b1;
    @(negedge clk);
    #1 a_start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("stall_pre_ch", a_ch, 3'd2);
    #1 a_ready = 1'b0; a_in = 32'hFEDC_BA98;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", a_valid, 1'b1);
      chk("stall_ch", a_ch, 3'd2);
      chk("stall_data", a_data, 4'h2);
    end
    #1 a_ready = 1'b1;
    @(negedge clk);
    chk("resume_ch", a_ch, 3'd3);
    chk("resume_data", a_data, 4'hB);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (a_done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("stall_done_seen", seen, 1'b1);
    @(negedge clk);
    check_acc(base);
    #1 a_in = 32'h7654_3210;

    // reset in the middle of a sweep
    a_start = 1'b1;
    @(negedge clk);
    #1 a_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a_valid && a_ch == 3'd4) seen = 1'b1;
    end
    chk("ch4_seen", seen, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_valid, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_done", a_done, 1'b0);
    chk("mid_rst_data", a_data, 4'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    scan_full();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
